// File: rtl/muldiv_fu_pkg.sv
// Shared types and constants for the RV32M multiply/divide functional unit.
package muldiv_fu_pkg;

  localparam int XLEN     = 32;
  localparam int ROB_IX_W = 3;
  localparam int OPCODE_W = 4;
  localparam int CNT_W    = 6;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [OPCODE_W-1:0] {
    MF_MUL    = 4'd0,
    MF_MULH   = 4'd1,
    MF_MULHSU = 4'd2,
    MF_MULHU  = 4'd3,
    MF_DIV    = 4'd4,
    MF_DIVU   = 4'd5,
    MF_REM    = 4'd6,
    MF_REMU   = 4'd7
  } muldiv_func_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } fu_state_e;

endpackage

// File: rtl/muldiv_fu_iter_divider.sv
// Unsigned restoring divider, one quotient bit per cycle; done flags the final iteration.
module muldiv_fu_iter_divider
  import muldiv_fu_pkg::*;
(
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            start,
  input  logic            abort,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  logic [CNT_W-1:0] count_q;
  logic [XLEN-1:0]  quot_q;
  logic [XLEN-1:0]  rem_q;
  logic [XLEN-1:0]  dvs_q;
  logic [XLEN:0]    shifted;
  logic [XLEN:0]    trial;

  assign shifted   = {rem_q, quot_q[XLEN-1]};
  assign trial     = shifted - {1'b0, dvs_q};
  assign done      = (count_q == CNT_W'(1));
  assign quotient  = quot_q;
  assign remainder = rem_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      count_q <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
    end else if (abort) begin
      count_q <= '0;
      rem_q   <= '0;
    end else if (start) begin
      count_q <= CNT_W'(XLEN);
      quot_q  <= dividend;
      rem_q   <= '0;
      dvs_q   <= divisor;
    end else if (count_q != '0) begin
      count_q <= count_q - CNT_W'(1);
      // borrow out of the trial subtract means the shifted remainder is smaller than the divisor
      if (!trial[XLEN]) begin
        rem_q  <= trial[XLEN-1:0];
        quot_q <= {quot_q[XLEN-2:0], 1'b1};
      end else begin
        rem_q  <= shifted[XLEN-1:0];
        quot_q <= {quot_q[XLEN-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_fu.sv
// RV32M multiply/divide unit: one op at a time from the reservation station, result held on the CDB until granted.
//   state | meaning
//   IDLE  | free, accepts valid_in
//   MUL   | registering the 64-bit product
//   DIV   | iterative divider running
//   DONE  | loads result on entry, then requests the CDB until granted
module muldiv_fu
  import muldiv_fu_pkg::*;
(
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                valid_in,
  input  logic [XLEN-1:0]     rval1_in,
  input  logic [XLEN-1:0]     rval2_in,
  input  logic [OPCODE_W-1:0] opcode_in,
  input  logic [ROB_IX_W-1:0] rob_ix_in,
  input  logic                flush_in,
  input  logic                cdb_grant_in,
  output logic                fu_busy_out,
  output logic                cdb_req_out,
  output logic [XLEN-1:0]     cdb_value_out,
  output logic [ROB_IX_W-1:0] cdb_rob_ix_out
);

  fu_state_e           state_q;
  logic [XLEN-1:0]     a_q, b_q;
  logic [OPCODE_W-1:0] op_q;
  logic [ROB_IX_W-1:0] rob_q;
  logic                special_q;
  logic [2*XLEN-1:0]   prod_q, prod_full, a_ext, b_ext;
  logic                in_div, in_signed, in_special, div_start, div_done;
  logic [XLEN-1:0]     dvd_mag, dvs_mag, quotient, remainder, q_fix, r_fix, result;
  logic                q_signed, mul_hi;

  assign fu_busy_out = (state_q != ST_IDLE);

  assign in_div     = (opcode_in[3:2] == 2'b01);
  assign in_signed  = ~opcode_in[0];
  assign in_special = in_div && ((rval2_in == '0) ||
                      (in_signed && rval1_in == INT_MIN && rval2_in == '1));
  assign dvd_mag    = (in_signed && rval1_in[XLEN-1]) ? -rval1_in : rval1_in;
  assign dvs_mag    = (in_signed && rval2_in[XLEN-1]) ? -rval2_in : rval2_in;
  assign div_start  = (state_q == ST_IDLE) && valid_in && !flush_in && in_div && !in_special;

  muldiv_fu_iter_divider u_div (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .start     (div_start),
    .abort     (flush_in),
    .dividend  (dvd_mag),
    .divisor   (dvs_mag),
    .done      (div_done),
    .quotient  (quotient),
    .remainder (remainder)
  );

  // Sign-extend to 64 bits only for operands the op treats as signed; the low 64 bits of the
  // product are then correct for every variant.
  assign a_ext     = {{XLEN{a_q[XLEN-1] & (op_q == MF_MULH || op_q == MF_MULHSU)}}, a_q};
  assign b_ext     = {{XLEN{b_q[XLEN-1] & (op_q == MF_MULH)}}, b_q};
  assign prod_full = a_ext * b_ext;
  assign mul_hi    = (op_q == MF_MULH) || (op_q == MF_MULHSU) || (op_q == MF_MULHU);

  assign q_signed = ~op_q[0];
  assign q_fix    = (q_signed && (a_q[XLEN-1] ^ b_q[XLEN-1])) ? -quotient : quotient;
  assign r_fix    = (q_signed && a_q[XLEN-1]) ? -remainder : remainder;

  always_comb begin
    result = '0;
    if (op_q[3:2] != 2'b01) begin
      result = mul_hi ? prod_q[2*XLEN-1:XLEN] : prod_q[XLEN-1:0];
    end else if (special_q) begin
      if (b_q == '0) result = op_q[1] ? a_q : '1;
      else           result = op_q[1] ? '0  : INT_MIN;
    end else begin
      result = op_q[1] ? r_fix : q_fix;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q        <= ST_IDLE;
      a_q            <= '0;
      b_q            <= '0;
      op_q           <= '0;
      rob_q          <= '0;
      special_q      <= 1'b0;
      prod_q         <= '0;
      cdb_req_out    <= 1'b0;
      cdb_value_out  <= '0;
      cdb_rob_ix_out <= '0;
    end else if (flush_in) begin
      state_q     <= ST_IDLE;
      cdb_req_out <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (valid_in) begin
            a_q       <= rval1_in;
            b_q       <= rval2_in;
            op_q      <= opcode_in;
            rob_q     <= rob_ix_in;
            special_q <= in_special;
            if (!in_div)         state_q <= ST_MUL;
            else if (in_special) state_q <= ST_DONE;
            else                 state_q <= ST_DIV;
          end
        end
        ST_MUL: begin
          prod_q  <= prod_full;
          state_q <= ST_DONE;
        end
        ST_DIV: begin
          if (div_done) state_q <= ST_DONE;
        end
        ST_DONE: begin
          if (cdb_req_out && cdb_grant_in) begin
            state_q     <= ST_IDLE;
            cdb_req_out <= 1'b0;
          end else if (!cdb_req_out) begin
            cdb_req_out    <= 1'b1;
            cdb_value_out  <= result;
            cdb_rob_ix_out <= rob_q;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_fu.sv
// Self-checking bench for muldiv_fu: directed vector table, random ops against an arithmetic model, handshake corners.
module tb_muldiv_fu;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        valid_in;
  logic [31:0] rval1_in, rval2_in;
  logic [3:0]  opcode_in;
  logic [2:0]  rob_ix_in;
  logic        flush_in;
  logic        cdb_grant_in;
  logic        fu_busy_out;
  logic        cdb_req_out;
  logic [31:0] cdb_value_out;
  logic [2:0]  cdb_rob_ix_out;

  int total = 0;
  int bad   = 0;

  muldiv_fu dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .valid_in       (valid_in),
    .rval1_in       (rval1_in),
    .rval2_in       (rval2_in),
    .opcode_in      (opcode_in),
    .rob_ix_in      (rob_ix_in),
    .flush_in       (flush_in),
    .cdb_grant_in   (cdb_grant_in),
    .fu_busy_out    (fu_busy_out),
    .cdb_req_out    (cdb_req_out),
    .cdb_value_out  (cdb_value_out),
    .cdb_rob_ix_out (cdb_rob_ix_out)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #1ms;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  rob;
    logic [31:0] val;
    int          lat;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // RV32M semantics in plain 64-bit arithmetic.
  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, ub, p;
    longint unsigned up;
    logic [63:0]     r;
    sa = $signed(a);
    sb = $signed(b);
    ub = {32'b0, b};
    case (op)
      4'd1: begin p = sa * sb; r = p; return r[63:32]; end
      4'd2: begin p = sa * ub; r = p; return r[63:32]; end
      4'd3: begin up = {32'b0, a} * {32'b0, b}; r = up; return r[63:32]; end
      4'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        p = sa / sb; r = p; return r[31:0];
      end
      4'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      4'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        p = sa % sb; r = p; return r[31:0];
      end
      4'd7: return (b == 0) ? a : a % b;
      default: return a * b;
    endcase
  endfunction

  function automatic int model_lat(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op < 4 || op > 7) return 2;
    if (b == 0) return 1;
    if ((op == 4 || op == 6) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
    return 33;
  endfunction

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [2:0] rob);
    opcode_in = op; rval1_in = a; rval2_in = b; rob_ix_in = rob; valid_in = 1'b1;
    @(posedge clk_in); #1;
    valid_in = 1'b0;
  endtask

  task automatic wait_req(input string tag, output int lat);
    lat = 0;
    while (!cdb_req_out && lat < 60) begin
      @(posedge clk_in); #1;
      lat++;
    end
    if (!cdb_req_out) chk({tag, "_req_timeout"}, 32'(cdb_req_out), 32'd1);
  endtask

  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] rob, input logic [31:0] exp_val, input int exp_lat,
                       input string tag);
    int lat;
    issue(op, a, b, rob);
    wait_req(tag, lat);
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_value"}, cdb_value_out, exp_val);
    chk({tag, "_rob"}, 32'(cdb_rob_ix_out), 32'(rob));
    cdb_grant_in = 1'b1;
    @(posedge clk_in); #1;
    cdb_grant_in = 1'b0;
    chk({tag, "_busy_after_grant"}, 32'(fu_busy_out), 32'd0);
    chk({tag, "_req_after_grant"}, 32'(cdb_req_out), 32'd0);
  endtask

  initial begin
    int          lat, hits;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic [2:0]  rob;

    vecs[0]  = '{4'd0, 32'd7,        32'hFFFFFFFD, 3'd5, 32'hFFFFFFEB, 2};
    vecs[1]  = '{4'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'd1, 32'hFFFFFFFE, 2};
    vecs[2]  = '{4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'd2, 32'h00000000, 2};
    vecs[3]  = '{4'd2, 32'hFFFFFFFF, 32'd2,        3'd3, 32'hFFFFFFFF, 2};
    vecs[4]  = '{4'd9, 32'd6,        32'd7,        3'd4, 32'd42,       2};
    vecs[5]  = '{4'd4, 32'hFFFFFFEC, 32'd3,        3'd6, 32'hFFFFFFFA, 33};
    vecs[6]  = '{4'd6, 32'hFFFFFFEC, 32'd3,        3'd7, 32'hFFFFFFFE, 33};
    vecs[7]  = '{4'd5, 32'd100,      32'd7,        3'd0, 32'd14,       33};
    vecs[8]  = '{4'd4, 32'd5,        32'd0,        3'd1, 32'hFFFFFFFF, 1};
    vecs[9]  = '{4'd7, 32'd5,        32'd0,        3'd2, 32'd5,        1};
    vecs[10] = '{4'd4, 32'h80000000, 32'hFFFFFFFF, 3'd3, 32'h80000000, 1};
    vecs[11] = '{4'd6, 32'h80000000, 32'hFFFFFFFF, 3'd4, 32'h00000000, 1};
    vecs[12] = '{4'd5, 32'h80000000, 32'hFFFFFFFF, 3'd5, 32'h00000000, 33};
    vecs[13] = '{4'd7, 32'h80000000, 32'hFFFFFFFF, 3'd6, 32'h80000000, 33};
    vecs[14] = '{4'd6, 32'd7,        32'hFFFFFFFE, 3'd7, 32'd1,        33};
    vecs[15] = '{4'd5, 32'd0,        32'd9,        3'd0, 32'd0,        33};

    rst_in = 1'b1; valid_in = 1'b0; flush_in = 1'b0; cdb_grant_in = 1'b0;
    rval1_in = '0; rval2_in = '0; opcode_in = '0; rob_ix_in = '0;
    #12;
    chk("reset_busy", 32'(fu_busy_out), 32'd0);
    chk("reset_req", 32'(cdb_req_out), 32'd0);
    chk("reset_value", cdb_value_out, 32'd0);
    chk("reset_rob", 32'(cdb_rob_ix_out), 32'd0);
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    @(posedge clk_in); #1;

    foreach (vecs[i])
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rob, vecs[i].val, vecs[i].lat,
            $sformatf("vec%0d", i));

    for (int i = 0; i < 30; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'hFFFFFFFF;
        2: b = 32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) a = 32'h80000000;
      rob = 3'($urandom_range(0, 7));
      do_op(op, a, b, rob, model(op, a, b), model_lat(op, a, b), $sformatf("rand%0d_op%0d", i, op));
    end

    // Grant withheld in DONE; issue attempts while busy must be ignored.
    issue(4'd0, 32'd3, 32'd4, 3'd2);
    wait_req("hold", lat);
    for (int k = 0; k < 10; k++) begin
      opcode_in = 4'd5; rval1_in = 32'd99; rval2_in = 32'd9; rob_ix_in = 3'd7;
      valid_in = (k % 2 == 0);
      @(posedge clk_in); #1;
      chk($sformatf("hold%0d_req", k), 32'(cdb_req_out), 32'd1);
      chk($sformatf("hold%0d_value", k), cdb_value_out, 32'd12);
      chk($sformatf("hold%0d_rob", k), 32'(cdb_rob_ix_out), 32'd2);
      chk($sformatf("hold%0d_busy", k), 32'(fu_busy_out), 32'd1);
    end
    valid_in = 1'b1; cdb_grant_in = 1'b1;
    @(posedge clk_in); #1;
    valid_in = 1'b0; cdb_grant_in = 1'b0;
    chk("grant_with_valid_busy", 32'(fu_busy_out), 32'd0);
    chk("grant_with_valid_req", 32'(cdb_req_out), 32'd0);
    do_op(4'd5, 32'd100, 32'd7, 3'd3, 32'd14, 33, "after_hold");

    // Flush at DIV cycle 10.
    issue(4'd4, 32'd1000, 32'd7, 3'd1);
    repeat (9) begin @(posedge clk_in); #1; end
    chk("flush_pre_busy", 32'(fu_busy_out), 32'd1);
    flush_in = 1'b1;
    @(posedge clk_in); #1;
    flush_in = 1'b0;
    chk("flush_busy", 32'(fu_busy_out), 32'd0);
    chk("flush_req", 32'(cdb_req_out), 32'd0);
    hits = 0;
    repeat (40) begin @(posedge clk_in); #1; if (cdb_req_out || fu_busy_out) hits++; end
    chk("flush_quiet", 32'(hits), 32'd0);
    do_op(4'd4, 32'hFFFFFFEC, 32'd3, 3'd6, 32'hFFFFFFFA, 33, "after_flush");

    // Reset between edges while holding a result.
    issue(4'd0, 32'h1234, 32'h10, 3'd4);
    wait_req("rst_done", lat);
    chk("rst_done_value", cdb_value_out, 32'h12340);
    #3 rst_in = 1'b1;
    #1;
    chk("rst_mid_busy", 32'(fu_busy_out), 32'd0);
    chk("rst_mid_req", 32'(cdb_req_out), 32'd0);
    chk("rst_mid_value", cdb_value_out, 32'd0);
    chk("rst_mid_rob", 32'(cdb_rob_ix_out), 32'd0);
    @(posedge clk_in); #1;
    rst_in = 1'b0;

    // Reset while the divider is running.
    issue(4'd4, 32'd500, 32'd3, 3'd5);
    repeat (5) begin @(posedge clk_in); #1; end
    #3 rst_in = 1'b1;
    #1;
    chk("rst_div_busy", 32'(fu_busy_out), 32'd0);
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    do_op(4'd7, 32'd100, 32'd7, 3'd2, 32'd2, 33, "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
